// File: rtl/mfa_row_mult_seq.sv
// Iterative unsigned multiplier: one row of modified-full-adder cells, one multiplier bit per cycle.
// Optional MFA_ZERO_BYPASS_EN: zero operands skip straight to DONE one cycle after acceptance.
module mfa_row_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the producer keeps valid and data stable until that edge, and ready never depends on valid.

    localparam int ROW_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic [WIDTH-1:0]     c_q, c_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     pp;
    logic [WIDTH-1:0]     cell_sum;
    logic [WIDTH-1:0]     cell_carry;
    logic                 last_row;

`ifdef MFA_ZERO_BYPASS_EN
    logic                 zero_op;
    assign zero_op = (a == '0) || (b == '0);
`endif

    // B shifts right each row, so the current multiplier bit is always b_q[0].
    assign pp       = a_q & {WIDTH{b_q[0]}};
    assign last_row = (row_q == ROW_W'(WIDTH - 1));

    always_comb begin
        cell_sum   = '0;
        cell_carry = '0;
        for (int j = 0; j < WIDTH; j++) begin
            cell_sum[j]   = pp[j] ^ s_q[j] ^ c_q[j];
            cell_carry[j] = (pp[j] & s_q[j]) | (pp[j] & c_q[j]) | (s_q[j] & c_q[j]);
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        c_d       = c_q;
        lo_d      = lo_q;
        row_d     = row_q;
        product_d = product_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    s_d   = '0;
                    c_d   = '0;
                    lo_d  = '0;
                    row_d = '0;
`ifdef MFA_ZERO_BYPASS_EN
                    if (zero_op) begin
                        state_d   = ST_DONE;
                        product_d = '0;
                    end else begin
                        state_d   = ST_ACCUM;
                    end
`else
                    state_d = ST_ACCUM;
`endif
                end
            end

            ST_ACCUM: begin
                // Sums move down one weight per row; carries stay aligned to the next row's weight.
                s_d   = {1'b0, cell_sum[WIDTH-1:1]};
                c_d   = cell_carry;
                lo_d  = {cell_sum[0], lo_q[WIDTH-1:1]};
                b_d   = b_q >> 1;
                row_d = row_q + ROW_W'(1);
                if (last_row) begin
                    state_d = ST_RESOLVE;
                end
            end

            ST_RESOLVE: begin
                product_d = {s_q + c_q, lo_q};
                state_d   = ST_DONE;
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            c_q       <= '0;
            lo_q      <= '0;
            row_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            c_q       <= c_d;
            lo_q      <= lo_d;
            row_q     <= row_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mfa_row_mult_seq.sv
// Bench for mfa_row_mult_seq: directed literal cases, mid-operation reset, and randomized traffic
// checked every cycle against a transaction-level model (expected products queue + cycle timing).
module tb_mfa_row_mult_seq;
  localparam int W = 8;
  localparam int LAT = W + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] product;
  logic           busy;
  logic [1:0]     dbg_state;

  mfa_row_mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_res = 0;

  // Model state: one operation in flight at most, products in acceptance order.
  logic [2*W-1:0] exp_q[$];
  bit             inflight = 1'b0;
  int             ov_cyc = 0;
  logic [2*W-1:0] last_prod = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Latency counted from the cycle in which in_valid && in_ready is seen.
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MFA_ZERO_BYPASS_EN
    if (x == '0 || y == '0) return 1;
`endif
    return LAT;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic           exp_ov;
    logic [2*W-1:0] exp_cur;
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_product", product, 0);
      inflight = 1'b0;
      last_prod = '0;
      exp_q.delete();
    end else begin
      exp_cur = (exp_q.size() > 0) ? exp_q[0] : '0;
      exp_ov = inflight && (cyc >= ov_cyc);
      chk("in_ready", in_ready, !inflight);
      chk("busy", busy, inflight);
      chk("out_valid", out_valid, exp_ov);
      chk("product", product, exp_ov ? exp_cur : last_prod);
      if (exp_ov && out_valid && out_ready) begin
        last_prod = exp_q.pop_front();
        inflight = 1'b0;
        n_res++;
      end else if (!inflight && in_valid && in_ready) begin
        exp_q.push_back((2*W)'(a) * (2*W)'(b));
        inflight = 1'b1;
        ov_cyc = cyc + exp_lat(a, b);
        n_acc++;
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [2*W-1:0] lit, input int lit_lat, input int hold);
    bit ok;
    int c_acc;
    int c_ov;
    c_acc = 0;
    c_ov = 0;
    @(posedge clk); #1;
    a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; c_acc = cyc; end
    end
    chk("accept_seen", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; c_ov = cyc; end
    end
    chk("result_seen", ok, 1);
    chk("latency_lit", c_ov - c_acc, lit_lat);
    chk("product_lit", product, lit);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = h[0]; a = W'($urandom); b = W'($urandom);
    end
    if (hold > 0) begin
      @(negedge clk);
      chk("held_product_lit", product, lit);
      chk("held_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int res0;
    bit ok;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_op(8'd13, 8'd11, 16'd143, 10, 0);
    do_op(8'd255, 8'd255, 16'hFE01, 10, 0);
    do_op(8'd255, 8'd1, 16'd255, 10, 0);
    do_op(8'd1, 8'd128, 16'd128, 10, 0);
`ifdef MFA_ZERO_BYPASS_EN
    do_op(8'd0, 8'd200, 16'd0, 1, 0);
`else
    do_op(8'd0, 8'd200, 16'd0, 10, 0);
`endif
    do_op(8'd37, 8'd91, 16'd3367, 10, 20);

    // Abort an operation with reset while it is accumulating row 4.
    @(posedge clk); #1;
    a = 8'd200; b = 8'd3; in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    chk("abort_accept_seen", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_product", product, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(8'd6, 8'd7, 16'd42, 10, 0);

    // Saturating traffic with random backpressure.
    acc0 = n_acc;
    res0 = n_res;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? W'(0) :
          ($urandom_range(0, 7) == 0) ? W'(255) : W'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("random_one_result_per_accept", n_res - res0, n_acc - acc0);
    chk("random_enough_traffic", (n_acc - acc0) > 20, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
